spi_master_param: RTL and testbench

//  Parametrised full-duplex SPI master. Successor to the fixed 12-bit, mode-0, transmit-only master.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sclk_gen.sv | 42 ++++
 rtl/spi_master_param.sv | 144 ++++++++++++++
 tb/tb_spi_master_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and width helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GUARD} spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Width of a counter that must be able to hold the value max_count.
  function automatic int ctr_w(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Divider and sclk register: one tick every CLK_DIV cycles while run is high,
// sclk toggles on ticks while en is high and rests at CPOL otherwise.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic en,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge,
  output logic sclk
);

  localparam int               DIV_W    = ctr_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             sclk_reg;

  assign tick = run && (div_cnt_reg == DIV_LAST);

  // Reload to zero on each terminal count so every period is exactly CLK_DIV.
  always_ff @(posedge clk) begin
    if (rst || !run || tick) div_cnt_reg <= '0;
    else                     div_cnt_reg <= div_cnt_reg + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || !en) sclk_reg <= CPOL;
    else if (tick)  sclk_reg <= ~sclk_reg;
  end

  assign lead_edge  = en && tick && (sclk_reg == CPOL);
  assign trail_edge = en && tick && (sclk_reg != CPOL);
  assign sclk       = sclk_reg;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master (width, divider, CPOL/CPHA, bit order).
// Define SPI_MASTER_LOOPBACK_EN to feed the rx shifter from internal mosi instead of miso.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int CLK_DIV   = 10,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int               BIT_W    = ctr_w(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam spi_mode_t        MODE     = '{cpol: CPOL, cpha: CPHA};

  spi_state_t        state_reg, state_next;
  logic [DATA_W-1:0] tx_sh_reg, rx_sh_reg, rx_data_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic              cs_n_reg, mosi_reg, tx_ready_reg, rx_valid_reg, busy_reg;
  logic              tick, lead_edge, trail_edge, sample_edge, shift_edge;
  logic              accept, rx_in;

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  spi_sclk_gen #(.CLK_DIV(CLK_DIV), .CPOL(MODE.cpol)) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (state_reg != IDLE),
    .en         (state_reg == SHIFT),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sclk       (sclk)
  );

  assign accept      = (state_reg == IDLE) && tx_valid && tx_ready_reg;
  assign sample_edge = MODE.cpha ? trail_edge : lead_edge;
  assign shift_edge  = MODE.cpha ? lead_edge : trail_edge;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_in       = mosi_reg;
`else
  assign rx_in = miso;
`endif

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   if (tick) state_next = SHIFT;
      SHIFT:   if (trail_edge && (bit_cnt_reg == BIT_LAST)) state_next = HOLD;
      HOLD:    if (tick) state_next = GUARD;
      GUARD:   if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      tx_sh_reg    <= '0;
      rx_sh_reg    <= '0;
      rx_data_reg  <= '0;
      bit_cnt_reg  <= '0;
      cs_n_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
      tx_ready_reg <= 1'b1;
      rx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rx_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: if (accept) begin
          cs_n_reg     <= 1'b0;
          tx_ready_reg <= 1'b0;
          busy_reg     <= 1'b1;
          bit_cnt_reg  <= '0;
          rx_sh_reg    <= '0;
          // CPHA=0 presents the first bit before the first sampling edge.
          if (!MODE.cpha) begin
            mosi_reg  <= out_bit(tx_data);
            tx_sh_reg <= shift_out(tx_data);
          end else begin
            tx_sh_reg <= tx_data;
          end
        end
        SHIFT: begin
          if (sample_edge) rx_sh_reg <= shift_in(rx_sh_reg, rx_in);
          if (shift_edge) begin
            mosi_reg  <= out_bit(tx_sh_reg);
            tx_sh_reg <= shift_out(tx_sh_reg);
          end
          if (trail_edge) bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
        end
        HOLD: if (tick) begin
          cs_n_reg     <= 1'b1;
          mosi_reg     <= 1'b0;
          rx_data_reg  <= rx_sh_reg;
          rx_valid_reg <= 1'b1;
        end
        GUARD: if (tick) begin
          tx_ready_reg <= 1'b1;
          busy_reg     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tx_ready = tx_ready_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign busy     = busy_reg;
  assign cs_n     = cs_n_reg;
  assign mosi     = mosi_reg;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: four instances (mode0 LSB-first, modes 1/2/3 MSB-first),
// a bit-level slave model on each, table-driven frames plus back-to-back, reset and busy cases.
module tb_spi_master_param;

  localparam int         N      = 4;
  localparam int         DW     = 12;
  localparam int         DIV    = 2;
  localparam logic [3:0] CPOL_V = 4'b1100;
  localparam logic [3:0] CPHA_V = 4'b1010;
  localparam logic [3:0] LSB_V  = 4'b0001;
`ifdef SPI_MASTER_LOOPBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tx_data [N];
  logic [N-1:0]  tx_valid;
  logic [N-1:0]  miso;
  wire  [N-1:0]  tx_ready, rx_valid, busy, sclk, cs_n, mosi;
  wire  [DW-1:0] rx_data [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    spi_master_param #(
      .DATA_W(DW), .CLK_DIV(DIV), .CPOL(CPOL_V[gi]), .CPHA(CPHA_V[gi]), .LSB_FIRST(LSB_V[gi])
    ) u_dut (
      .clk(clk), .rst(rst), .tx_data(tx_data[gi]), .tx_valid(tx_valid[gi]),
      .tx_ready(tx_ready[gi]), .rx_data(rx_data[gi]), .rx_valid(rx_valid[gi]),
      .busy(busy[gi]), .sclk(sclk[gi]), .cs_n(cs_n[gi]), .mosi(mosi[gi]), .miso(miso[gi])
    );
  end

  // Slave model state
  logic [DW-1:0] slave_word [N];
  int            bit_idx [N];
  logic [DW-1:0] cap_word [N];
  logic [N-1:0]  first_bit;
  logic [N-1:0]  sclk_prev = '0;
  logic [N-1:0]  cs_prev = '1;
  int            cs_low [N];
  int            gap [N];
  int            last_gap [N];
  int            toggles [N];
  int            ready_viol;
  logic [DW-1:0] cap_q [N][$];
  logic [DW-1:0] rx_q [N][$];

  int pass_cnt = 0;
  int total = 0;

  always_comb begin
    miso = '0;
    for (int i = 0; i < N; i++) begin
      if (bit_idx[i] < DW)
        miso[i] = LSB_V[i] ? slave_word[i][bit_idx[i]] : slave_word[i][DW-1-bit_idx[i]];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!cs_n[i]) begin
        if (cs_prev[i]) begin
          last_gap[i] = gap[i];
          cs_low[i]   = 0;
          toggles[i]  = 0;
          bit_idx[i]  = 0;
          cap_word[i] = '0;
        end
        cs_low[i]++;
        if (sclk[i] != sclk_prev[i]) begin
          toggles[i]++;
          if ((sclk[i] != CPOL_V[i]) == (CPHA_V[i] == 1'b0)) begin
            if (bit_idx[i] == 0) first_bit[i] = mosi[i];
            if (bit_idx[i] < DW) begin
              if (LSB_V[i]) cap_word[i][bit_idx[i]] = mosi[i];
              else          cap_word[i][DW-1-bit_idx[i]] = mosi[i];
            end
            bit_idx[i]++;
          end
        end
      end else begin
        if (!cs_prev[i]) cap_q[i].push_back(cap_word[i]);
        gap[i]     = cs_prev[i] ? gap[i] + 1 : 1;
        bit_idx[i] = 0;
      end
      if (rx_valid[i]) rx_q[i].push_back(rx_data[i]);
      if (busy[i] == tx_ready[i]) ready_viol++;
      sclk_prev[i] = sclk[i];
      cs_prev[i]   = cs_n[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic run_frame(input int i, input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                           output bit ok);
    int n;
    slave_word[i] = sw;
    cap_q[i].delete();
    rx_q[i].delete();
    @(negedge clk);
    tx_data[i]  = tx;
    tx_valid[i] = 1'b1;
    n = 0;
    @(posedge clk); #1;
    while (tx_ready[i] && n < 100) begin @(posedge clk); #1; n++; end
    tx_valid[i] = 1'b0;
    tx_data[i]  = ~tx;
    n = 0;
    while (busy[i] && n < 500) begin @(negedge clk); n++; end
    ok = !busy[i];
  endtask

  task automatic frame_test(input string tag, input int i, input logic [DW-1:0] tx,
                            input logic [DW-1:0] sw, input logic first);
    bit            ok;
    logic [DW-1:0] exp_rx;
    exp_rx = LOOP ? tx : sw;
    check({tag, "_idle_before"}, 32'(sclk[i]), 32'(CPOL_V[i]));
    run_frame(i, tx, sw, ok);
    @(negedge clk);
    check({tag, "_done"}, 32'(ok), 1);
    check({tag, "_frames"}, cap_q[i].size(), 1);
    check({tag, "_mosi_word"}, (cap_q[i].size() > 0) ? 32'(cap_q[i][0]) : 32'hFFFF_FFFF, 32'(tx));
    check({tag, "_first_bit"}, 32'(first_bit[i]), 32'(first));
    check({tag, "_rx_pulses"}, rx_q[i].size(), 1);
    check({tag, "_rx_data"}, 32'(rx_data[i]), 32'(exp_rx));
    check({tag, "_cs_low"}, cs_low[i], DIV * (2 * DW + 2));
    check({tag, "_idle_after"}, 32'(sclk[i]), 32'(CPOL_V[i]));
    check({tag, "_ready_after"}, 32'(tx_ready[i]), 1);
  endtask

  typedef struct {
    int            inst;
    logic [DW-1:0] tx;
    logic [DW-1:0] sw;
    logic          first;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    int to;
    tx_valid = '0;
    for (int i = 0; i < N; i++) begin
      tx_data[i]    = '0;
      slave_word[i] = '0;
    end
    vecs[0] = '{0, 12'hA5C, 12'h3C1, 1'b0};
    vecs[1] = '{0, 12'h5A5, 12'h000, 1'b1};
    vecs[2] = '{1, 12'h801, 12'h6B2, 1'b1};
    vecs[3] = '{1, 12'h123, 12'hFED, 1'b0};
    vecs[4] = '{2, 12'h801, 12'h0F0, 1'b1};
    vecs[5] = '{2, 12'hA5C, 12'h3C1, 1'b1};
    vecs[6] = '{3, 12'h801, 12'h5A5, 1'b1};
    vecs[7] = '{3, 12'h3E7, 12'h18C, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst%0d_sclk", i), 32'(sclk[i]), 32'(CPOL_V[i]));
      check($sformatf("rst%0d_cs_n", i), 32'(cs_n[i]), 1);
      check($sformatf("rst%0d_mosi", i), 32'(mosi[i]), 0);
      check($sformatf("rst%0d_tx_ready", i), 32'(tx_ready[i]), 1);
      check($sformatf("rst%0d_rx_valid", i), 32'(rx_valid[i]), 0);
      check($sformatf("rst%0d_rx_data", i), 32'(rx_data[i]), 0);
      check($sformatf("rst%0d_busy", i), 32'(busy[i]), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++)
      frame_test($sformatf("v%0d", v), vecs[v].inst, vecs[v].tx, vecs[v].sw, vecs[v].first);

    // Back-to-back: tx_valid held across two frames
    to = 0;
    slave_word[0] = 12'h3C1;
    cap_q[0].delete();
    rx_q[0].delete();
    @(negedge clk);
    tx_data[0]  = 12'h111;
    tx_valid[0] = 1'b1;
    n = 0; while (cs_n[0] && n < 100) begin @(negedge clk); n++; end
    to += (n >= 100);
    tx_data[0] = 12'h222;
    n = 0; while (!cs_n[0] && n < 200) begin @(negedge clk); n++; end
    to += (n >= 200);
    n = 0; while (cs_n[0] && n < 100) begin @(negedge clk); n++; end
    to += (n >= 100);
    tx_valid[0] = 1'b0;
    n = 0; while (busy[0] && n < 200) begin @(negedge clk); n++; end
    to += (n >= 200);
    repeat (5) @(negedge clk);
    check("b2b_timeout", to, 0);
    check("b2b_frames", cap_q[0].size(), 2);
    check("b2b_word0", (cap_q[0].size() > 0) ? 32'(cap_q[0][0]) : 32'hFFFF_FFFF, 32'h111);
    check("b2b_word1", (cap_q[0].size() > 1) ? 32'(cap_q[0][1]) : 32'hFFFF_FFFF, 32'h222);
    check("b2b_rx_pulses", rx_q[0].size(), 2);
    check("b2b_rx0", (rx_q[0].size() > 0) ? 32'(rx_q[0][0]) : 32'hFFFF_FFFF, LOOP ? 32'h111 : 32'h3C1);
    check("b2b_rx1", (rx_q[0].size() > 1) ? 32'(rx_q[0][1]) : 32'hFFFF_FFFF, LOOP ? 32'h222 : 32'h3C1);
    check("b2b_gap_ok", 32'(last_gap[0] >= DIV + 1), 1);

    // Reset at the 7th sclk toggle
    rx_q[0].delete();
    slave_word[0] = 12'h777;
    @(negedge clk);
    tx_data[0]  = 12'hABC;
    tx_valid[0] = 1'b1;
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    n = 0; while (toggles[0] != 7 && n < 200) begin @(negedge clk); n++; end
    check("rstmid_reach7", 32'(toggles[0]), 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_cs_n", 32'(cs_n[0]), 1);
    check("rstmid_sclk", 32'(sclk[0]), 32'(CPOL_V[0]));
    check("rstmid_mosi", 32'(mosi[0]), 0);
    check("rstmid_tx_ready", 32'(tx_ready[0]), 1);
    check("rstmid_busy", 32'(busy[0]), 0);
    repeat (20) @(negedge clk);
    check("rstmid_no_rx_valid", rx_q[0].size(), 0);
    frame_test("rstmid_next", 0, 12'h0F0, 12'h2D4, 1'b0);

    // tx_valid pulse while busy is ignored
    slave_word[0] = 12'h000;
    cap_q[0].delete();
    @(negedge clk);
    tx_data[0]  = 12'h456;
    tx_valid[0] = 1'b1;
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    check("busy_accepted", 32'(busy[0]), 1);
    repeat (10) @(negedge clk);
    tx_data[0]  = 12'h999;
    tx_valid[0] = 1'b1;
    check("busy_ready_low", 32'(tx_ready[0]), 0);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    n = 0; while (busy[0] && n < 200) begin @(negedge clk); n++; end
    check("busy_done", 32'(busy[0]), 0);
    repeat (10) @(negedge clk);
    check("busy_cs_idle", 32'(cs_n[0]), 1);
    check("busy_frames", cap_q[0].size(), 1);
    check("busy_word", (cap_q[0].size() > 0) ? 32'(cap_q[0][0]) : 32'hFFFF_FFFF, 32'h456);
    check("ready_vs_busy", ready_viol, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
